// File: rtl/gray_seq_ctrl.sv
// Walks a binary count start->end (up/down, single/loop) and streams registered Gray words.
// First word one cycle after start; word and count hold while ready is low.
module gray_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  input  logic             dir,
  input  logic             wrap,
  input  logic             abort,
  input  logic             ready,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef struct packed {
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] end_val;
    logic             dir;
    logic             wrap;
  } cfg_t;

  // One-hot so that valid/busy/done decode straight from state flops.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    EMIT = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t           state;
  state_t           state_nxt;
  cfg_t             cfg;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray;
  logic             load;
  logic             xfer;
  logic             last;

  assign load = (state == IDLE) && start;
  assign xfer = (state == EMIT) && ready;
  assign last = (bin == cfg.end_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (xfer && last && !cfg.wrap) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid = (state == EMIT);
    busy  = (state != IDLE);
    done  = (state == DONE);
  end

  // An aborted handshake still consumes the word, but the count is left alone.
  always_comb begin
    bin_nxt = bin;
    if (load) begin
      bin_nxt = start_val;
    end else if (xfer && !abort) begin
      if (last) begin
        bin_nxt = cfg.wrap ? cfg.start_val : bin;
      end else begin
        bin_nxt = cfg.dir ? (bin - 1'b1) : (bin + 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin  <= '0;
      gray <= '0;
      cfg  <= '0;
    end else begin
      bin  <= bin_nxt;
      gray <= bin_nxt ^ (bin_nxt >> 1);
      if (load) begin
        cfg <= '{start_val, end_val, dir, wrap};
      end
    end
  end

  assign bin_out  = bin;
  assign gray_out = gray;

endmodule

// File: doc/gray_seq_ctrl.md
# gray_seq_ctrl

Sequencing controller for the binary-to-Gray conversion path. On a start command it walks a binary count from a programmed start value to an end value, up or down, in single-step or continuous-loop mode. It presents each Gray-coded word to a downstream consumer over a valid/ready handshake. The block owns the count register that feeds the bin-to-Gray function, so downstream logic sees one registered Gray word per accepted transfer.

## Interface

Parameters:
- WIDTH, 4, width of the binary count and the Gray word.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle command; accepted only in IDLE.
- start_val  in  WIDTH  first binary value of the sequence; sampled on accepted start.
- end_val  in  WIDTH  last binary value of the sequence; sampled on accepted start.
- dir  in  1  0 = count up, 1 = count down; sampled on accepted start.
- wrap  in  1  0 = stop after end_val, 1 = loop start_val..end_val forever; sampled on accepted start.
- abort  in  1  terminate a running sequence.
- ready  in  1  consumer accepts gray_out this cycle.
- gray_out  out  WIDTH  registered Gray word, always bin_out ^ (bin_out >> 1).
- bin_out  out  WIDTH  registered binary count behind gray_out.
- valid  out  1  gray_out/bin_out hold a word to transfer.
- busy  out  1  sequence in progress (EMIT or DONE).
- done  out  1  one-cycle pulse after the final word of a non-wrapping sequence.

## Operation

- States: IDLE, EMIT, DONE.
- IDLE:
  - valid=0, busy=0, done=0.
  - start=1 → bin<=start_val, gray<=gray(start_val), latch end_val/dir/wrap (and start_val for looping) → EMIT.
- EMIT: valid=1, busy=1. A transfer occurs on a cycle with valid=1 and ready=1.
  - Transfer, bin==end_r, wrap_r=0 → DONE; bin/gray unchanged.
  - Transfer, bin==end_r, wrap_r=1 → bin<=start_r; stay in EMIT.
  - Transfer otherwise → bin<=bin+1 (dir=0) or bin-1 (dir=1), modulo 2^WIDTH; gray updated in the same edge.
  - No transfer → bin, gray, valid held stable.
- DONE: valid=0, busy=1, done=1 for exactly one cycle → IDLE.
- Abort:
  - Takes effect in EMIT only, and beats every other transition, including a final transfer.
  - Next state is IDLE, with valid=0 the following cycle and no done pulse.
  - If abort coincides with a handshake, that word counts as consumed.
- start outside IDLE is ignored, and so is abort in IDLE/DONE.
- Input changes to start_val, end_val, dir and wrap after an accepted start do not affect the running sequence.
- Words per non-wrapping sequence: ((end_val − start_val) mod 2^WIDTH) + 1 counting up, or ((start_val − end_val) mod 2^WIDTH) + 1 counting down. A sequence with start_val==end_val emits one word.
- Counting through 2^WIDTH−1 → 0 (up) or 0 → 2^WIDTH−1 (down) is legal and is not a terminal condition.

## Timing

- Reset (rst=1 at an edge) is synchronous and overrides everything, including mid-sequence.
  - Next cycle: state=IDLE, bin_out=0, gray_out=0, valid=0, busy=0, done=0.
  - No done pulse on reset.
- Start latency: start accepted at edge N → valid=1 with gray(start_val) during cycle N+1.
- Throughput: with ready held high, one word per cycle and no bubbles, including across loop restarts.
- Final word accepted at edge M → done=1 and valid=0 during cycle M+1, IDLE from edge M+1.
  - The earliest new start is sampled at edge M+2.
- All outputs are registered; there are no combinational paths from ready, start or abort to any output.

## Test plan

- Up count, single pass, ready=1: rst; start_val=0, end_val=12, dir=0, wrap=0.
  - gray_out is 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010 on 13 consecutive cycles.
  - Then one cycle with done=1 and valid=0, then busy=0.
- Down count through zero: start_val=2, end_val=14, dir=1, ready=1.
  - bin_out is 2,1,0,15,14; gray_out is 0011,0001,0000,1000,1001.
  - done pulses once.
- Backpressure: start_val=3, end_val=6, up; ready toggles 1,0,0,1,0,1,1.
  - gray_out holds its value and valid stays 1 on every ready=0 cycle.
  - Exactly 4 words are transferred: 0010,0110,0111,0101.
- Loop and abort: start_val=5, end_val=6, wrap=1, ready=1.
  - gray_out alternates 0111,0101,0111,0101, ... with no done pulse.
  - Abort asserted → valid=0 the next cycle, state IDLE, done stays 0.
- Single word plus ignored start: start_val=end_val=9.
  - One word 1101, then done.
  - A start pulse while valid=1 or in DONE is ignored: latched values and word count unchanged.
- Reset mid-run: start 0→15 up, rst=1 after 5 words.
  - Next cycle: valid=0, busy=0, done=0, gray_out=0000.
  - A fresh start afterwards behaves as in the first scenario.
